// File: rtl/klingon_scan_ctrl.sv
// ============================================================================
// Module   : klingon_scan_ctrl
// Purpose  : Time-multiplexed scan controller that shares one external
//            combinational 4-bit -> 7-segment Klingon glyph decoder across
//            NUM_DIGITS common-anode digits. Holds a double-buffered frame
//            (pending/active), steps the decoder input through each digit,
//            and registers the decoder result together with the anode select.
// Options  : KLINGON_SCAN_BLANK_EN - when defined, an all-off BLANK guard of
//            BLANK_CYCLES precedes every digit; otherwise digits switch
//            back-to-back.
// Ports    : clk, rst_n      - clock (rising edge), async active-low reset
//            enable          - 1 = scan, 0 = park in IDLE with display dark
//            load_valid/ready/data - host frame handshake, digit i at [4i+3:4i]
//            dec_in/dec_out  - shared glyph decoder request/result
//            seg, an         - registered segments (act-high), anodes (act-low)
//            frame_done      - one-cycle pulse when the last digit's dwell ends
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module klingon_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              dec_in,
    input  logic [6:0]              dec_out,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int c_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0]    c_DWELL_LAST = c_CNT_W'(DWELL_CYCLES - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST   = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_AN_ONE     = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF     = '1;
`ifdef KLINGON_SCAN_BLANK_EN
    localparam logic [c_CNT_W-1:0]    c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // State that follows IDLE and every completed SHOW dwell.
`ifdef KLINGON_SCAN_BLANK_EN
    localparam state_t c_DIGIT_ENTRY = ST_BLANK;
`else
    localparam state_t c_DIGIT_ENTRY = ST_SHOW;
`endif

    state_t                    r_state, w_state_nxt;
    logic [c_IDX_W-1:0]        r_idx,   w_idx_nxt;
    logic [c_CNT_W-1:0]        r_cnt,   w_cnt_nxt;
    logic [4*NUM_DIGITS-1:0]   r_active;
    logic [4*NUM_DIGITS-1:0]   r_pending;
    logic                      r_pending_valid;
    logic [6:0]                r_seg;
    logic [NUM_DIGITS-1:0]     r_an;
    logic                      r_frame_done;

    logic                      w_dwell_end;
    logic                      w_last_digit;
    logic                      w_frame_end;
    logic                      w_xfer;
    logic                      w_accept;
    logic [NUM_DIGITS-1:0]     w_an_sel;

    assign w_dwell_end  = (r_cnt == c_DWELL_LAST);
    assign w_last_digit = (r_idx == c_IDX_LAST);
    // A dropped enable aborts the frame, so no boundary and no frame_done.
    assign w_frame_end  = enable && (r_state == ST_SHOW) && w_dwell_end && w_last_digit;

    // Pending frame is promoted only while parked or exactly at a frame
    // boundary, so the active frame is never torn mid-scan.
    assign w_xfer     = r_pending_valid && ((r_state == ST_IDLE) || w_frame_end);
    assign load_ready = !r_pending_valid || w_xfer;
    assign w_accept   = load_valid && load_ready;

    assign dec_in   = r_active[{r_idx, 2'b00} +: 4];
    assign w_an_sel = ~(c_AN_ONE << r_idx);

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

    // ------------------------------------------------------------------
    // Scan sequencer: state, digit index and dwell/blank counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = c_DIGIT_ENTRY;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
`ifdef KLINGON_SCAN_BLANK_EN
                ST_BLANK: begin
                    if (r_cnt == c_BLANK_LAST) begin
                        w_state_nxt = ST_SHOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
                    end
                end
`endif
                ST_SHOW: begin
                    if (w_dwell_end) begin
                        w_state_nxt = c_DIGIT_ENTRY;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = w_last_digit ? '0 : r_idx + c_IDX_W'(1);
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame buffers and registered display outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active        <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_seg           <= 7'h00;
            r_an            <= c_AN_OFF;
            r_frame_done    <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_active <= r_pending;
            end
            // Accept and transfer in one cycle keeps pending_valid set.
            if (w_accept) begin
                r_pending       <= load_data;
                r_pending_valid <= 1'b1;
            end else if (w_xfer) begin
                r_pending_valid <= 1'b0;
            end

            r_frame_done <= w_frame_end;

            // seg and an update on the same edge so no digit ghosts.
            if (r_state == ST_SHOW) begin
                r_seg <= dec_out;
                r_an  <= w_an_sel;
            end else begin
                r_seg <= 7'h00;
                r_an  <= c_AN_OFF;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_klingon_scan_ctrl.sv
// ============================================================================
// Module   : tb_klingon_scan_ctrl
// Purpose  : Self-checking bench for klingon_scan_ctrl (4 digits, dwell 8,
//            blank 2). A time-position model predicts the display from the
//            number of cycles since scanning began.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_klingon_scan_ctrl;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int BL = 2;
`ifdef KLINGON_SCAN_BLANK_EN
    localparam int B = 2;
`else
    localparam int B = 0;
`endif
    localparam int P  = D + B;
    localparam int FP = N * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = 16'h0000;
    logic [3:0]  dec_in;
    logic [6:0]  dec_out;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    assign dec_out = glyph(dec_in);

    klingon_scan_ctrl #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(D),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .dec_in    (dec_in),
        .dec_out   (dec_out),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: scan position is just "cycles since leaving IDLE".
    // ------------------------------------------------------------------
    bit          m_run  = 1'b0;
    int          m_t    = 0;
    logic [15:0] m_act  = '0;
    logic [15:0] m_pend = '0;
    bit          m_pv   = 1'b0;
    logic [6:0]  e_seg  = 7'h00;
    logic [3:0]  e_an   = 4'hF;
    logic        e_fd   = 1'b0;

    function automatic bit m_frame_end(input logic en);
        return en && m_run && ((m_t % FP) == FP - 1);
    endfunction

    function automatic int m_digit();
        return m_run ? (m_t / P) % N : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_act = '0; m_pend = '0; m_pv = 0;
            e_seg = 7'h00; e_an = 4'hF; e_fd = 1'b0;
        end else begin
            bit showing, fend, xfer, ready;
            int dig;
            showing = m_run && ((m_t % P) >= B);
            dig     = m_digit();
            e_seg   = showing ? glyph(m_act[4*dig +: 4]) : 7'h00;
            e_an    = showing ? ~(4'b0001 << dig) : 4'hF;
            fend    = m_frame_end(enable);
            e_fd    = fend;
            xfer    = m_pv && (!m_run || fend);
            ready   = !m_pv || xfer;
            if (xfer) m_act = m_pend;
            if (load_valid && ready) begin
                m_pend = load_data;
                m_pv   = 1;
            end else if (xfer) begin
                m_pv = 0;
            end
            if (!enable) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t = (m_t + 1) % FP;
            end
        end
    end

    // Single compare process, mid low phase of the clock.
    always @(negedge clk) begin
        #2;
        chk("seg", seg, e_seg);
        chk("an", an, e_an);
        chk("frame_done", frame_done, e_fd);
        chk("load_ready", load_ready, !m_pv || (m_pv && (!m_run || m_frame_end(enable))));
        chk("dec_in", dec_in, m_act[4*m_digit() +: 4]);
    end

    task automatic wait_an(input logic [3:0] v, input string nm);
        bit hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk); #1;
            if (an == v) hit = 1;
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s timeout waiting an actual=%0h required=%0h", nm, an, v);
        end
    endtask

    initial begin
        logic [3:0] an_log [0:127];
        int  f1, f2;
        bit  hit;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_seg", seg, 7'h00);
        chk("rst_an", an, 4'hF);
        chk("rst_ready", load_ready, 1'b1);
        chk("rst_fd", frame_done, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // Load 3210 while parked, then scan
        @(negedge clk); load_valid = 1'b1; load_data = 16'h3210;
        @(negedge clk); load_valid = 1'b0;
        @(negedge clk); enable = 1'b1;
        f1 = -1; f2 = -1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk); #1;
            an_log[k] = an;
            if (frame_done) begin
                if (f1 < 0) f1 = k;
                else if (f2 < 0) f2 = k;
            end
        end
        chk("an_pre_first", an_log[1 + B], 4'hF);
        chk("an_digit0", an_log[2 + B], 4'b1110);
        chk("an_digit1", an_log[2 + B + P], 4'b1101);
        chk("an_digit3", an_log[2 + B + 3*P], 4'b0111);
`ifdef KLINGON_SCAN_BLANK_EN
        chk("frame_period", f2 - f1, 40);
`else
        chk("frame_period", f2 - f1, 32);
`endif

        // Two loads in one frame: second stalls until the boundary
        @(negedge clk); load_valid = 1'b1; load_data = 16'hAAAA;
        @(negedge clk); load_data = 16'h5555; #1;
        chk("stall_ready", load_ready, 1'b0);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk); #1;
            if (load_ready) hit = 1;
        end
        chk("boundary_reached", hit, 1'b1);
        @(negedge clk); load_valid = 1'b0; #1;
        chk("boundary_fd", frame_done, 1'b1);
        chk("pend_kept_ready", load_ready, 1'b0);
        repeat (2 * FP + 4) @(negedge clk);

        // Reset during digit 2
        wait_an(4'b1011, "wait_digit2");
        rst_n = 1'b0; #1;
        chk("midrst_seg", seg, 7'h00);
        chk("midrst_an", an, 4'hF);
        chk("midrst_ready", load_ready, 1'b1);
        @(negedge clk); rst_n = 1'b1;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk); #1;
            if (an != 4'hF) begin
                hit = 1;
                chk("restart_digit0", an, 4'b1110);
            end
        end
        chk("restart_seen", hit, 1'b1);

        // Drop enable during digit 1
        wait_an(4'b1101, "wait_digit1");
        enable = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("dis_an", an, 4'hF);
        chk("dis_seg", seg, 7'h00);
        @(negedge clk); enable = 1'b1;
        wait_an(4'b1110, "reenable_digit0");

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom);
            rst_n      = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk); rst_n = 1'b1; load_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
